// File: rtl/pipe_stage_chain.sv
// Elastic register chain of DEPTH stages with valid/ready handshake,
// stall absorption, synchronous flush and NOP_VAL bubbles in empty stages.
module pipe_stage_chain #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1,
    parameter logic [31:0] NOP_VAL = 32'h0000_0013
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Flush,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [DATA_W-1:0]          InData,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [DATA_W-1:0]          OutData,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [DATA_W-1:0] NOP_D = DATA_W'(NOP_VAL);
    localparam logic [DEPTH-1:0] ONES = '1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  stage_rdy;
    logic              in_xfer, out_xfer;

    // A stage can advance when any stage at or beyond it is empty, or the sink drains.
    always_comb begin
        stage_rdy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            stage_rdy[k] = OutReady | (|(~valid_q & (ONES << k)));
        end
    end

    assign InReady  = stage_rdy[0] & ~Flush;
    assign OutValid = valid_q[DEPTH-1] & ~Flush;
    assign OutData  = data_q[DEPTH-1];
    assign Count    = count_q;

    assign in_xfer  = InValid & InReady;
    assign out_xfer = OutValid & OutReady;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (Flush) begin
            valid_d = '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_d[k] = NOP_D;
            end
            count_d = '0;
        end else begin
            if (stage_rdy[0]) begin
                valid_d[0] = InValid;
                data_d[0]  = InValid ? InData : NOP_D;
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (stage_rdy[k]) begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = valid_q[k-1] ? data_q[k-1] : NOP_D;
                end
            end
            count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= NOP_D;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed and random checks of pipe_stage_chain at DEPTH 1, 2, 3 and 8
// against a slot-array model plus an in-order scoreboard of accepted beats.
module tb_pipe_stage_chain;

    localparam int NI = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rs [NI], fl [NI], iv [NI], ordy [NI], ir [NI], ov [NI];
    logic [31:0] id [NI], od [NI];
    logic [0:0]  cnt0;
    logic [1:0]  cnt1, cnt2;
    logic [3:0]  cnt3;

    int total = 0;
    int bad   = 0;

    // model: slot occupancy/data per instance, and a ring of accepted beats
    logic        mv  [NI][8];
    logic [31:0] md  [NI][8];
    int          mcnt[NI];
    logic [31:0] acc [NI][1024];
    int          wp  [NI], rp [NI];
    logic [31:0] av  [4];

    pipe_stage_chain #(.DATA_W(32), .DEPTH(1), .NOP_VAL(32'h13)) u_d1 (
        .Clk(clk), .Rst(rs[0]), .Flush(fl[0]), .InValid(iv[0]), .InReady(ir[0]),
        .InData(id[0]), .OutValid(ov[0]), .OutReady(ordy[0]), .OutData(od[0]), .Count(cnt0));
    pipe_stage_chain #(.DATA_W(32), .DEPTH(2), .NOP_VAL(32'h13)) u_d2 (
        .Clk(clk), .Rst(rs[1]), .Flush(fl[1]), .InValid(iv[1]), .InReady(ir[1]),
        .InData(id[1]), .OutValid(ov[1]), .OutReady(ordy[1]), .OutData(od[1]), .Count(cnt1));
    pipe_stage_chain #(.DATA_W(32), .DEPTH(3), .NOP_VAL(32'h13)) u_d3 (
        .Clk(clk), .Rst(rs[2]), .Flush(fl[2]), .InValid(iv[2]), .InReady(ir[2]),
        .InData(id[2]), .OutValid(ov[2]), .OutReady(ordy[2]), .OutData(od[2]), .Count(cnt2));
    pipe_stage_chain #(.DATA_W(32), .DEPTH(8), .NOP_VAL(32'h13)) u_d8 (
        .Clk(clk), .Rst(rs[3]), .Flush(fl[3]), .InValid(iv[3]), .InReady(ir[3]),
        .InData(id[3]), .OutValid(ov[3]), .OutReady(ordy[3]), .OutData(od[3]), .Count(cnt3));

    function automatic int depth_of(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 3;
            default: return 8;
        endcase
    endfunction

    function automatic int dut_cnt(input int i);
        case (i)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    // highest empty slot, or -1 when every slot holds a beat
    function automatic int top_hole(input int i);
        for (int j = depth_of(i) - 1; j >= 0; j--) begin
            if (!mv[i][j]) return j;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int i);
        for (int k = 0; k < 8; k++) begin
            mv[i][k] = 1'b0;
            md[i][k] = NOP;
        end
        mcnt[i] = 0;
        rp[i]   = wp[i];
    endtask

    task automatic model_step(input int i);
        int top, h;
        bit in_x, out_x;
        top = depth_of(i) - 1;
        if (rs[i] || fl[i]) begin
            model_clear(i);
            return;
        end
        h     = ordy[i] ? top : top_hole(i);
        in_x  = iv[i] && (h >= 0);
        out_x = mv[i][top] && ordy[i];
        for (int k = h; k >= 1; k--) begin
            mv[i][k] = mv[i][k-1];
            md[i][k] = md[i][k-1];
        end
        if (h >= 0) begin
            mv[i][0] = iv[i];
            md[i][0] = iv[i] ? id[i] : NOP;
        end
        if (out_x) rp[i]++;
        if (in_x) begin
            acc[i][wp[i] % 1024] = id[i];
            wp[i]++;
        end
        mcnt[i] = mcnt[i] + int'(in_x) - int'(out_x);
    endtask

    task automatic settle();
        #1;
    endtask

    // compare every instance with the model, clock once, advance the model
    task automatic tick();
        for (int i = 0; i < NI; i++) begin
            int top;
            top = depth_of(i) - 1;
            check($sformatf("in_ready[d%0d]", depth_of(i)), 32'(ir[i]),
                  32'((ordy[i] || top_hole(i) >= 0) && !fl[i]));
            check($sformatf("out_valid[d%0d]", depth_of(i)), 32'(ov[i]), 32'(mv[i][top] && !fl[i]));
            check($sformatf("out_data[d%0d]", depth_of(i)), od[i], md[i][top]);
            check($sformatf("count[d%0d]", depth_of(i)), 32'(dut_cnt(i)), 32'(mcnt[i]));
            if (ov[i] && ordy[i])
                check($sformatf("fifo_order[d%0d]", depth_of(i)), od[i], acc[i][rp[i] % 1024]);
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_step(i);
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; id[i] = 32'h0; ordy[i] = 1'b1; fl[i] = 1'b0; rs[i] = 1'b0;
        end
    endtask

    initial begin
        av[0] = 32'hA1; av[1] = 32'hA2; av[2] = 32'hA3; av[3] = 32'hA4;
        idle_all();
        for (int i = 0; i < NI; i++) begin
            rs[i] = 1'b1; wp[i] = 0; rp[i] = 0;
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_clear(i);
        @(negedge clk);
        settle();
        tick();

        // first cycle after reset release; DEPTH=2 streaming starts here
        idle_all();
        iv[1] = 1'b1; id[1] = 32'h11;
        settle();
        for (int i = 0; i < NI; i++) begin
            check("reset_out_valid", 32'(ov[i]), 32'h0);
            check("reset_out_data", od[i], 32'h13);
            check("reset_count", 32'(dut_cnt(i)), 32'h0);
            check("reset_in_ready", 32'(ir[i]), 32'h1);
        end
        tick();
        id[1] = 32'h22; settle(); tick();
        id[1] = 32'h33; settle();
        check("stream_c2_data", od[1], 32'h11);
        check("stream_c2_count", 32'(cnt1), 32'h2);
        tick();
        iv[1] = 1'b0; settle();
        check("stream_c3_data", od[1], 32'h22);
        check("stream_c3_count", 32'(cnt1), 32'h2);
        tick();
        settle();
        check("stream_c4_data", od[1], 32'h33);
        check("stream_c4_valid", 32'(ov[1]), 32'h1);
        tick();
        settle();
        check("stream_c5_nop", od[1], 32'h13);
        tick();

        // DEPTH=3 backpressure then drain
        ordy[2] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            iv[2] = 1'b1; id[2] = av[j]; settle();
            check("bp_accept", 32'(ir[2]), 32'h1);
            tick();
        end
        id[2] = av[3];
        for (int j = 0; j < 2; j++) begin
            settle();
            check("bp_full_ready", 32'(ir[2]), 32'h0);
            check("bp_full_count", 32'(cnt2), 32'h3);
            check("bp_hold_data", od[2], 32'hA1);
            tick();
        end
        ordy[2] = 1'b1; settle();
        check("bp_release_ready", 32'(ir[2]), 32'h1);
        check("bp_out0", od[2], av[0]);
        tick();
        iv[2] = 1'b0;
        for (int j = 1; j < 4; j++) begin
            settle();
            check("bp_out_seq", od[2], av[j]);
            tick();
        end

        // DEPTH=2 flush on a full chain
        ordy[1] = 1'b0; iv[1] = 1'b1;
        id[1] = 32'h1; settle(); tick();
        id[1] = 32'h2; settle(); tick();
        fl[1] = 1'b1; id[1] = 32'hBEEF; settle();
        check("flush_out_valid", 32'(ov[1]), 32'h0);
        check("flush_in_ready", 32'(ir[1]), 32'h0);
        tick();
        fl[1] = 1'b0; iv[1] = 1'b0; ordy[1] = 1'b1; settle();
        check("flush_count", 32'(cnt1), 32'h0);
        check("flush_data", od[1], 32'h13);
        for (int j = 0; j < 3; j++) begin
            settle(); tick();
        end

        // DEPTH=3 bubble absorption under stall
        ordy[2] = 1'b0;
        iv[2] = 1'b1; id[2] = 32'h5; settle(); tick();
        iv[2] = 1'b0; settle(); tick();
        iv[2] = 1'b1; id[2] = 32'h6; settle(); tick();
        iv[2] = 1'b0; settle();
        check("bubble_count", 32'(cnt2), 32'h2);
        check("bubble_in_ready", 32'(ir[2]), 32'h1);
        ordy[2] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            settle(); tick();
        end

        // DEPTH=1 simultaneous in/out, then reset mid-stream
        iv[0] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            id[0] = 32'h100 + 32'(j); settle();
            if (j > 0) begin
                check("simul_count", 32'(cnt0), 32'h1);
                check("simul_data", od[0], 32'h100 + 32'(j - 1));
                check("simul_in_ready", 32'(ir[0]), 32'h1);
            end
            tick();
        end
        rs[0] = 1'b1; settle(); tick();
        rs[0] = 1'b0; iv[0] = 1'b0; settle();
        check("simul_rst_count", 32'(cnt0), 32'h0);
        check("simul_rst_valid", 32'(ov[0]), 32'h0);
        tick();

        // random traffic on all instances, with stall bursts, flushes and resets
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NI; i++) begin
                rs[i]   = ($urandom_range(0, 149) == 0);
                fl[i]   = ($urandom_range(0, 39) == 0);
                iv[i]   = ($urandom_range(0, 3) != 0);
                id[i]   = $urandom;
                ordy[i] = ((n / 40) % 3 == 2) ? ($urandom_range(0, 4) == 0)
                                              : ($urandom_range(0, 3) != 0);
            end
            settle();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
